// File: rtl/memory_arbiter_if.sv
// Bundle of the icache/dcache miss ports and the main-memory port around memory_arbiter.
// The master view belongs to the arbiter; the slave view belongs to the caches and memory model.
`default_nettype none

interface memory_arbiter_if #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int CACHE_LINE_SIZE = 128
);
    logic                       icache_req_in;
    logic [ADDRESS_WIDTH-1:0]   icache_addr_in;
    logic                       icache_ready_out;
    logic [CACHE_LINE_SIZE-1:0] icache_data_out;

    logic                       dcache_req_in;
    logic                       dcache_write_in;
    logic [ADDRESS_WIDTH-1:0]   dcache_addr_in;
    logic [CACHE_LINE_SIZE-1:0] dcache_data_in;
    logic                       dcache_ready_out;
    logic [CACHE_LINE_SIZE-1:0] dcache_data_out;

    logic                       mem_enable_out;
    logic                       mem_op_out;
    logic [ADDRESS_WIDTH-1:0]   mem_addr_out;
    logic [CACHE_LINE_SIZE-1:0] mem_data_out;
    logic                       mem_ready_in;
    logic [CACHE_LINE_SIZE-1:0] mem_data_in;

    modport master (
        input  icache_req_in, icache_addr_in,
        output icache_ready_out, icache_data_out,
        input  dcache_req_in, dcache_write_in, dcache_addr_in, dcache_data_in,
        output dcache_ready_out, dcache_data_out,
        output mem_enable_out, mem_op_out, mem_addr_out, mem_data_out,
        input  mem_ready_in, mem_data_in
    );

    modport slave (
        output icache_req_in, icache_addr_in,
        input  icache_ready_out, icache_data_out,
        output dcache_req_in, dcache_write_in, dcache_addr_in, dcache_data_in,
        input  dcache_ready_out, dcache_data_out,
        input  mem_enable_out, mem_op_out, mem_addr_out, mem_data_out,
        output mem_ready_in, mem_data_in
    );
endinterface

`default_nettype wire

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the instruction and data caches.
// Serializes line transactions and routes each completed line back to its owning cache.
`default_nettype none

module memory_arbiter #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int CACHE_LINE_SIZE = 128
) (
    input  wire logic         clk,
    input  wire logic         reset,
    memory_arbiter_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic                       last_grant_q, last_grant_d;
    logic                       grant_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic                       op_q, op_d;
    logic [CACHE_LINE_SIZE-1:0] wdata_q, wdata_d;
    logic [CACHE_LINE_SIZE-1:0] idata_q, idata_d;
    logic [CACHE_LINE_SIZE-1:0] ddata_q, ddata_d;
    logic                       iready_q, iready_d;
    logic                       dready_q, dready_d;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = 1'b0;
        addr_d       = addr_q;
        op_d         = op_q;
        wdata_d      = wdata_q;
        idata_d      = idata_q;
        ddata_d      = ddata_q;
        iready_d     = 1'b0;
        dready_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.icache_req_in || bus.dcache_req_in) begin
                    // On a tie the cache that was not served last wins.
                    grant_d = (bus.icache_req_in && bus.dcache_req_in) ? ~last_grant_q
                                                                       : bus.dcache_req_in;
                    last_grant_d = grant_d;
                    if (grant_d) begin
                        state_d = SERVE_D;
                        addr_d  = bus.dcache_addr_in;
                        op_d    = bus.dcache_write_in;
                        wdata_d = bus.dcache_data_in;
                    end else begin
                        state_d = SERVE_I;
                        addr_d  = bus.icache_addr_in;
                        op_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            SERVE_I: begin
                if (bus.mem_ready_in) begin
                    idata_d  = bus.mem_data_in;
                    iready_d = 1'b1;
                    state_d  = RELEASE;
                end
            end
            SERVE_D: begin
                if (bus.mem_ready_in) begin
                    // A write-back returns no line, so the last fill stays visible.
                    if (!op_q) begin
                        ddata_d = bus.mem_data_in;
                    end
                    dready_d = 1'b1;
                    state_d  = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            addr_q       <= '0;
            op_q         <= 1'b0;
            wdata_q      <= '0;
            idata_q      <= '0;
            ddata_q      <= '0;
            iready_q     <= 1'b0;
            dready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            op_q         <= op_d;
            wdata_q      <= wdata_d;
            idata_q      <= idata_d;
            ddata_q      <= ddata_d;
            iready_q     <= iready_d;
            dready_q     <= dready_d;
        end
    end

    assign bus.mem_enable_out   = (state_q == SERVE_I) || (state_q == SERVE_D);
    assign bus.mem_op_out       = op_q;
    assign bus.mem_addr_out     = addr_q;
    assign bus.mem_data_out     = wdata_q;
    assign bus.icache_ready_out = iready_q;
    assign bus.icache_data_out  = idata_q;
    assign bus.dcache_ready_out = dready_q;
    assign bus.dcache_data_out  = ddata_q;

endmodule

`default_nettype wire

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single main-memory port between the instruction cache and the data cache of the Abejaruco core. Sits between the two cache miss interfaces and the memory module. Serializes line-sized read/write transactions and applies round-robin priority when both caches miss in the same cycle. Returns each completed line only to the cache that owns the transaction.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, byte address width on all address ports
- CACHE_LINE_SIZE, 128, line width in bits on all data ports

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- icache_req_in  in  1  icache miss request (read only); held until icache_ready_out
- icache_addr_in  in  ADDRESS_WIDTH  line address; stable while icache_req_in high
- icache_ready_out  out  1  one-cycle pulse: icache_data_out valid
- icache_data_out  out  CACHE_LINE_SIZE  line returned to icache
- dcache_req_in  in  1  dcache request; held until dcache_ready_out
- dcache_write_in  in  1  1 = write-back of dcache_data_in, 0 = line fill
- dcache_addr_in  in  ADDRESS_WIDTH  line address
- dcache_data_in  in  CACHE_LINE_SIZE  line to write (used when dcache_write_in = 1)
- dcache_ready_out  out  1  one-cycle pulse: transaction done / dcache_data_out valid
- dcache_data_out  out  CACHE_LINE_SIZE  line returned to dcache (reads only)
- mem_enable_out  out  1  memory transaction active
- mem_op_out  out  1  1 = write, 0 = read
- mem_addr_out  out  ADDRESS_WIDTH  memory address
- mem_data_out  out  CACHE_LINE_SIZE  write data to memory
- mem_ready_in  in  1  one-cycle pulse from memory: transaction complete
- mem_data_in  in  CACHE_LINE_SIZE  read data; valid when mem_ready_in = 1

## Operation
- States: IDLE, SERVE_I, SERVE_D, RELEASE. Register last_grant (0 = icache, 1 = dcache).
- IDLE: only icache_req_in -> SERVE_I; only dcache_req_in -> SERVE_D; both -> grant the cache not equal to last_grant; none -> stay.
- On grant: latch address, op, and write data into internal registers. Set last_grant to the winner.
- SERVE_x: drive mem_enable_out = 1 with latched addr/op/data. Requester inputs are ignored after the latch.
- mem_ready_in = 1 in SERVE_x: register mem_data_in into the winner's data_out and pulse the winner's ready_out for exactly one cycle. Drop mem_enable_out in the same transition. Go to RELEASE.
- For a dcache write: dcache_data_out is not updated; dcache_ready_out still pulses.
- RELEASE: one cycle, no grant. Lets the served requester drop req, then go to IDLE.
- A request arriving during SERVE_x/RELEASE waits; it is evaluated in IDLE.
- mem_ready_in outside SERVE_x is ignored.
- Loser of a tie is guaranteed service next (round-robin): no starvation under continuous requests from both caches.
- Data outputs hold their last value until the next completion for that cache.

## Timing
- Reset (reset = 0 at a rising edge):
  - state = IDLE, last_grant = 0 (icache), so dcache wins the first tie after reset.
  - All ready/enable/op outputs = 0; all address and data outputs = 0.
- Reset mid-transaction: abandon the transaction. mem_enable_out = 0 and no ready pulse is issued. The memory module is reset in the same cycle.
- Latency, request to grant: request high before edge N (state IDLE) -> mem_enable_out = 1 after edge N.
- Latency, memory to requester: mem_ready_in high before edge M -> ready_out = 1 and data valid after edge M, low after edge M+1.
- Minimum spacing between two grants: 3 cycles (SERVE with 1-cycle memory, RELEASE, IDLE). Total overhead is 2 cycles plus memory latency.
- mem_addr_out, mem_op_out and mem_data_out are stable for the full time mem_enable_out = 1.

## Test plan
- Single icache read: icache_req_in = 1, addr = 0x00000010; memory returns 0x00201083 in the low word after 4 cycles -> mem_enable_out high 4 cycles, mem_op_out = 0, mem_addr_out = 0x10, icache_ready_out pulses once with that data, dcache_ready_out stays 0.
- Simultaneous requests after reset: icache addr 0x0, dcache read addr 0x100 in the same cycle -> dcache served first (mem_addr_out = 0x100), then icache (0x0). Exactly one ready pulse each, in that order.
- Dcache write-back: dcache_write_in = 1, addr = 0x200, data = 0xFFFFFFFC repeated -> mem_op_out = 1, mem_data_out equals input line, dcache_ready_out pulses, dcache_data_out unchanged.
- Fairness: both requests held continuously for 6 transactions -> grants alternate D, I, D, I, D, I. No ready pulse on the non-granted cache.
- Reset mid-operation: reset = 0 while in SERVE_I, 2 cycles before mem_ready_in -> mem_enable_out = 0 next cycle, no icache_ready_out. A late mem_ready_in is ignored; the next tie again grants dcache.
- Spurious mem_ready_in in IDLE: no ready pulse, state remains IDLE, data outputs unchanged.
